// File: rtl/bth_pkg.sv
// Shared arithmetic-unit package: controller state encodings and the
// iteration-counter width helper used by bth_div and bth_mlt.
package bth_pkg;

  // Controller states (2-bit, legacy-compatible encoding)
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Counter must reach n, so it needs $clog2(n+1) bits
  function automatic int bth_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int BTH_N_DEF   = 3;
  localparam int BTH_CNT_W   = bth_cnt_w(BTH_N_DEF);

endpackage

// File: rtl/bth_abs.sv
// Conditional two's-complement negate.
// With neg tied to the operand's sign bit it yields the magnitude; the
// W-bit result is read as unsigned, so the most-negative value maps to
// 2^(W-1) exactly. With neg driven by a sign-fix flag it applies the
// final result sign.
module bth_abs #(
  parameter int W = 3
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  // Negate when requested, pass through otherwise
  always_comb begin
    res = neg ? (~val + W'(1)) : val;
  end

endmodule

// File: rtl/bth_div.sv
// bth_div: sequential restoring divider, one quotient bit per clock.
// Quotient truncates toward zero; Remainder carries the dividend's sign.
// Build option: define BTH_DIV_SIGNED_EN for two's-complement operands;
// left undefined, all operands and results are unsigned and the
// magnitude / sign-fix logic is not built. Latency is n+2 either way.
module bth_div
  import bth_pkg::*;
#(
  parameter int n = 3,
  parameter int N = 2 * n
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         start,
  input  logic [n-1:0] Dividend,
  input  logic [n-1:0] Divisor,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] Quotient,
  output logic [n-1:0] Remainder,
  output logic         div_by_zero
);

  localparam int CW = bth_cnt_w(n);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  aq_q, aq_d;      // {A, Q}: partial remainder over quotient
  logic [n-1:0]  m_q, m_d;        // divisor magnitude
  logic          done_q, done_d;
  logic          dz_q, dz_d;
  logic [n-1:0]  quo_q, quo_d;
  logic [n-1:0]  rem_q, rem_d;

  logic [n-1:0]  dvd_mag, dvs_mag, quo_fix, rem_fix;
  logic [n:0]    sh_a;            // A after the left shift, n+1 bits
  logic          ge;              // trial subtraction is non-negative
  logic [n-1:0]  a_new;

`ifdef BTH_DIV_SIGNED_EN
  logic sgn_dvd_q, sgn_dvd_d;
  logic sgn_dvs_q, sgn_dvs_d;

  bth_abs #(.W(n)) u_abs_dvd (.val(Dividend), .neg(Dividend[n-1]), .res(dvd_mag));
  bth_abs #(.W(n)) u_abs_dvs (.val(Divisor),  .neg(Divisor[n-1]),  .res(dvs_mag));
  bth_abs #(.W(n)) u_fix_quo (.val(aq_q[n-1:0]), .neg(sgn_dvd_q ^ sgn_dvs_q), .res(quo_fix));
  bth_abs #(.W(n)) u_fix_rem (.val(aq_q[N-1:n]), .neg(sgn_dvd_q),             .res(rem_fix));
`else
  assign dvd_mag = Dividend;
  assign dvs_mag = Divisor;
  assign quo_fix = aq_q[n-1:0];
  assign rem_fix = aq_q[N-1:n];
`endif

  // Shift step: new A is the old A with the quotient MSB shifted in.
  // A stays below M between steps, so n bits hold it; only the shifted
  // value needs the extra bit.
  assign sh_a  = aq_q[N-1:n-1];
  assign ge    = (sh_a >= {1'b0, m_q});
  assign a_new = ge ? (sh_a[n-1:0] - m_q) : sh_a[n-1:0];

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    aq_d    = aq_q;
    m_d     = m_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    done_d  = (state_q == S_DONE);
`ifdef BTH_DIV_SIGNED_EN
    sgn_dvd_d = sgn_dvd_q;
    sgn_dvs_d = sgn_dvs_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (Divisor == '0) begin
            // Division by zero skips the datapath entirely
            quo_d   = '1;
            rem_d   = Dividend;
            dz_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            aq_d    = {{n{1'b0}}, dvd_mag};
            m_d     = dvs_mag;
            count_d = '0;
            dz_d    = 1'b0;
`ifdef BTH_DIV_SIGNED_EN
            sgn_dvd_d = Dividend[n-1];
            sgn_dvs_d = Divisor[n-1];
`endif
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        aq_d    = {a_new, aq_q[n-2:0], ge};
        count_d = count_q + CW'(1);
        if (count_q == CW'(n - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        quo_d   = quo_fix;
        rem_d   = rem_fix;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers; clr aborts any operation at once
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      count_q <= '0;
      aq_q    <= '0;
      m_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
`ifdef BTH_DIV_SIGNED_EN
      sgn_dvd_q <= 1'b0;
      sgn_dvs_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      aq_q    <= aq_d;
      m_q     <= m_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
`ifdef BTH_DIV_SIGNED_EN
      sgn_dvd_q <= sgn_dvd_d;
      sgn_dvs_q <= sgn_dvs_d;
`endif
    end
  end

  assign busy        = (state_q == S_CALC) || (state_q == S_FIX);
  assign done        = done_q;
  assign Quotient    = quo_q;
  assign Remainder   = rem_q;
  assign div_by_zero = dz_q;

endmodule
